// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame controller: FSM state
// encoding, default frame constants and the length-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [7:0] SOF_DEFAULT     = 8'hA5;
  localparam int         MAX_LEN_DEFAULT = 16;
  localparam int         TIMEOUT_DEFAULT = 640;

  // Bits needed to hold a length value 0..max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int LW_DEFAULT = len_width(MAX_LEN_DEFAULT);

  // Modulo-256 checksum accumulation.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port and
// one combinational read port. Out-of-range read addresses return 0.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Storage write; cleared on reset so stale data never leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we && (waddr == AW'(i))) begin
          mem[i] <= wdata;
        end else begin
          mem[i] <= mem[i];
        end
      end
    end
  end

  // Combinational read mux.
  always_comb begin
    rdata = 8'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) begin
        rdata = mem[i];
      end else begin
        rdata = rdata;
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: parses SOF, LEN, payload, CHK from the byte
// stream, buffers the payload and drains it over valid/ready only when the
// checksum sums to zero mod 256. Optional inter-byte timeout is enabled by
// defining UART_RX_TIMEOUT_EN.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         MAX_LEN = MAX_LEN_DEFAULT,
  parameter logic [7:0] SOF     = SOF_DEFAULT,
`ifdef UART_RX_TIMEOUT_EN
  parameter int         TIMEOUT_CYC = TIMEOUT_DEFAULT,
`endif
  localparam int        LW      = len_width(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [7:0]    frm_data,
  output logic          frm_valid,
  input  logic          frm_ready,
  output logic          frm_last,
  output logic [LW-1:0] frm_len,
  output logic          frame_done,
  output logic          err_chk,
  output logic          err_len,
  output logic          err_ovf,
  output logic          err_tmo,
  output logic          busy
);

  state_t        state_r, state_n;
  logic [LW-1:0] len_r, len_n;
  logic [LW-1:0] wr_ptr_r, wr_ptr_n;
  logic [LW-1:0] rd_ptr_r, rd_ptr_n;
  logic [7:0]    sum_r, sum_n;
  logic          buf_we;
  logic [7:0]    buf_rdata;
  logic          draining;
  logic          last_beat;
  logic          frame_done_r, frame_done_n;
  logic          err_chk_r, err_chk_n;
  logic          err_len_r, err_len_n;
  logic          err_ovf_r, err_ovf_n;
`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timer_r, timer_n;
  logic          err_tmo_r, err_tmo_n;
`endif

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (LW)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (buf_we),
    .waddr (wr_ptr_r),
    .wdata (rx_data),
    .raddr (rd_ptr_r),
    .rdata (buf_rdata)
  );

  assign draining  = (state_r == ST_DRAIN);
  assign last_beat = draining && (rd_ptr_r == (len_r - LW'(1)));

  // Next-state, datapath and pulse decode for the frame parser.
  always_comb begin
    state_n      = state_r;
    len_n        = len_r;
    wr_ptr_n     = wr_ptr_r;
    rd_ptr_n     = rd_ptr_r;
    sum_n        = sum_r;
    buf_we       = 1'b0;
    frame_done_n = 1'b0;
    err_chk_n    = 1'b0;
    err_len_n    = 1'b0;
    err_ovf_n    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SOF)) begin
          state_n = ST_LEN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (rx_valid) begin
          if ((rx_data == 8'd0) || (int'(rx_data) > MAX_LEN)) begin
            err_len_n = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            len_n    = LW'(rx_data);
            sum_n    = rx_data;
            wr_ptr_n = {LW{1'b0}};
            state_n  = ST_PAYLOAD;
          end
        end else begin
          state_n = ST_LEN;
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          buf_we   = 1'b1;
          sum_n    = sum8(sum_r, rx_data);
          wr_ptr_n = wr_ptr_r + LW'(1);
          if (wr_ptr_r == (len_r - LW'(1))) begin
            state_n = ST_CHK;
          end else begin
            state_n = ST_PAYLOAD;
          end
        end else begin
          state_n = ST_PAYLOAD;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          if (sum8(sum_r, rx_data) == 8'd0) begin
            frame_done_n = 1'b1;
            rd_ptr_n     = {LW{1'b0}};
            state_n      = ST_DRAIN;
          end else begin
            err_chk_n = 1'b1;
            state_n   = ST_IDLE;
          end
        end else begin
          state_n = ST_CHK;
        end
      end
      ST_DRAIN: begin
        // Any byte arriving while the buffer drains is dropped.
        err_ovf_n = rx_valid;
        if (frm_ready) begin
          if (last_beat) begin
            rd_ptr_n = {LW{1'b0}};
            state_n  = ST_IDLE;
          end else begin
            rd_ptr_n = rd_ptr_r + LW'(1);
            state_n  = ST_DRAIN;
          end
        end else begin
          state_n = ST_DRAIN;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
`ifdef UART_RX_TIMEOUT_EN
    // Inter-byte timer: a byte in the expiry cycle wins over the abort.
    timer_n   = {TW{1'b0}};
    err_tmo_n = 1'b0;
    if ((state_r == ST_LEN) || (state_r == ST_PAYLOAD) || (state_r == ST_CHK)) begin
      if (rx_valid) begin
        timer_n = {TW{1'b0}};
      end else if (timer_r == TW'(TIMEOUT_CYC - 1)) begin
        err_tmo_n = 1'b1;
        state_n   = ST_IDLE;
      end else begin
        timer_n = timer_r + TW'(1);
      end
    end else begin
      timer_n = {TW{1'b0}};
    end
`endif
  end

  // State, datapath and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      len_r        <= {LW{1'b0}};
      wr_ptr_r     <= {LW{1'b0}};
      rd_ptr_r     <= {LW{1'b0}};
      sum_r        <= 8'd0;
      frame_done_r <= 1'b0;
      err_chk_r    <= 1'b0;
      err_len_r    <= 1'b0;
      err_ovf_r    <= 1'b0;
    end else begin
      state_r      <= state_n;
      len_r        <= len_n;
      wr_ptr_r     <= wr_ptr_n;
      rd_ptr_r     <= rd_ptr_n;
      sum_r        <= sum_n;
      frame_done_r <= frame_done_n;
      err_chk_r    <= err_chk_n;
      err_len_r    <= err_len_n;
      err_ovf_r    <= err_ovf_n;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  // Timeout counter and its abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r   <= {TW{1'b0}};
      err_tmo_r <= 1'b0;
    end else begin
      timer_r   <= timer_n;
      err_tmo_r <= err_tmo_n;
    end
  end

  assign err_tmo = err_tmo_r;
`else
  assign err_tmo = 1'b0;
`endif

  // Stream outputs are forced to zero outside DRAIN.
  assign frm_valid  = draining;
  assign frm_data   = draining ? buf_rdata : 8'd0;
  assign frm_last   = last_beat;
  assign frm_len    = draining ? len_r : {LW{1'b0}};
  assign frame_done = frame_done_r;
  assign err_chk    = err_chk_r;
  assign err_len    = err_len_r;
  assign err_ovf    = err_ovf_r;
  assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed frames plus random
// frames checked against a byte-level frame model. Timeout checks are built
// only when UART_RX_TIMEOUT_EN is defined.
module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int LW      = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic [7:0]    frm_data;
  logic          frm_valid;
  logic          frm_ready = 1'b0;
  logic          frm_last;
  logic [LW-1:0] frm_len;
  logic          frame_done, err_chk, err_len, err_ovf, err_tmo, busy;

  uart_rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .SOF(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .frm_data(frm_data), .frm_valid(frm_valid), .frm_ready(frm_ready),
    .frm_last(frm_last), .frm_len(frm_len), .frame_done(frame_done),
    .err_chk(err_chk), .err_len(err_len), .err_ovf(err_ovf),
    .err_tmo(err_tmo), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int last_byte_cyc = 0;
  int tmo_cyc = 0;
  int cnt_done = 0, cnt_chk = 0, cnt_len = 0, cnt_ovf = 0, cnt_tmo = 0, cnt_vcyc = 0;
  bit hold_ready = 1'b0;
  logic [7:0] got_q[$];
  bit         got_last_q[$];
  int         got_len_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    frm_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pulse counting, handshake stability, collected output beats.
  initial begin
    bit prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", 32'(frm_valid), 32'd1);
          check_eq("hold_data", 32'(frm_data), 32'(prev_data));
        end
        if (frame_done) begin
          cnt_done++;
          check_eq("done_latency", cyc, last_byte_cyc);
          check_eq("done_with_valid", 32'(frm_valid), 32'd1);
        end
        if (err_chk) cnt_chk++;
        if (err_len) cnt_len++;
        if (err_ovf) cnt_ovf++;
        if (err_tmo) begin
          cnt_tmo++;
          tmo_cyc = cyc;
        end
        if (frame_done | err_chk | err_len | err_ovf | err_tmo)
          check_eq("pulse_onehot", $countones({frame_done, err_chk, err_len, err_ovf, err_tmo}), 32'd1);
        if (frm_valid) cnt_vcyc++;
        if (frm_valid && frm_ready) begin
          got_q.push_back(frm_data);
          got_last_q.push_back(frm_last);
          got_len_q.push_back(int'(frm_len));
        end
        prev_stall = frm_valid && !frm_ready;
        prev_data  = frm_data;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    last_byte_cyc = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
    #1;
  endtask

  task automatic check_payload(input string tag, input logic [7:0] exp_pay[$]);
    check_eq({tag, "_count"}, got_q.size(), exp_pay.size());
    for (int i = 0; i < exp_pay.size() && i < got_q.size(); i++) begin
      check_eq({tag, "_data"}, 32'(got_q[i]), 32'(exp_pay[i]));
      check_eq({tag, "_last"}, 32'(got_last_q[i]), (i == exp_pay.size() - 1) ? 32'd1 : 32'd0);
      check_eq({tag, "_len"}, got_len_q[i], exp_pay.size());
    end
  endtask

  // Sends a byte sequence and checks pulse counts and delivered payload.
  task automatic run_frame(input string tag, input logic [7:0] bytes[$], input int exp_done,
                           input int exp_chk, input int exp_len, input logic [7:0] exp_pay[$]);
    int d0, c0, l0, o0, v0;
    got_q.delete(); got_last_q.delete(); got_len_q.delete();
    d0 = cnt_done; c0 = cnt_chk; l0 = cnt_len; o0 = cnt_ovf; v0 = cnt_vcyc;
    foreach (bytes[i]) send_byte(bytes[i], $urandom_range(0, 2));
    wait_idle(tag);
    check_eq({tag, "_done"}, cnt_done - d0, exp_done);
    check_eq({tag, "_errchk"}, cnt_chk - c0, exp_chk);
    check_eq({tag, "_errlen"}, cnt_len - l0, exp_len);
    check_eq({tag, "_errovf"}, cnt_ovf - o0, 32'd0);
    if (exp_done == 0) check_eq({tag, "_novalid"}, cnt_vcyc - v0, 32'd0);
    check_payload(tag, exp_pay);
  endtask

  initial begin
    logic [7:0] bq[$];
    logic [7:0] pq[$];
    logic [7:0] none[$];
    int len, sum, kind, chk, o0;

    none.delete();
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(frm_valid), 32'd0);
    check_eq("rst_errs", 32'({frame_done, err_chk, err_len, err_ovf, err_tmo}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_outs", 32'({frm_data, frm_last, frm_len, busy}), 32'd0);

    bq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    pq = {8'h11, 8'h22, 8'h33};
    run_frame("good3", bq, 1, 0, 0, pq);
    bq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    run_frame("badchk", bq, 0, 1, 0, none);
    bq = {8'hA5, 8'h00};
    run_frame("len0", bq, 0, 0, 1, none);
    bq = {8'hA5, 8'h11};
    run_frame("len17", bq, 0, 0, 1, none);
    bq = {8'h5A, 8'hA5, 8'h02, 8'hA5, 8'h10, 8'h49};
    pq = {8'hA5, 8'h10};
    run_frame("sof_in_data", bq, 1, 0, 0, pq);

    // Overflow while draining with the sink stalled.
    hold_ready = 1'b1;
    got_q.delete(); got_last_q.delete(); got_len_q.delete();
    bq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    foreach (bq[i]) send_byte(bq[i], 0);
    repeat (5) @(negedge clk);
    check_eq("stall_data", 32'(frm_data), 32'h11);
    check_eq("stall_len", 32'(frm_len), 32'd3);
    o0 = cnt_ovf;
    send_byte(8'hA5, 0);
    @(negedge clk);
    #1;
    check_eq("ovf_pulse", cnt_ovf - o0, 32'd1);
    check_eq("ovf_data_held", 32'(frm_data), 32'h11);
    hold_ready = 1'b0;
    wait_idle("ovf");
    pq = {8'h11, 8'h22, 8'h33};
    check_payload("ovf", pq);

    // Random frames from the frame-level model.
    for (int f = 0; f < 40; f++) begin
      bq.delete();
      pq.delete();
      for (int g = $urandom_range(0, 3); g > 0; g--) bq.push_back(8'($urandom_range(0, 8'hA4)));
      bq.push_back(8'hA5);
      kind = $urandom_range(0, 99);
      if (kind < 15) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        bq.push_back(8'(len));
        run_frame("rnd_len", bq, 0, 0, 1, none);
      end else begin
        len = $urandom_range(1, MAX_LEN);
        sum = len;
        bq.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
          pq.push_back(8'($urandom_range(0, 255)));
          sum += int'(pq[i]);
          bq.push_back(pq[i]);
        end
        chk = (256 - (sum % 256)) % 256;
        if (kind < 30) begin
          chk = (chk + $urandom_range(1, 255)) % 256;
          bq.push_back(8'(chk));
          run_frame("rnd_chk", bq, 0, 1, 0, none);
        end else begin
          bq.push_back(8'(chk));
          run_frame("rnd_good", bq, 1, 0, 0, pq);
        end
      end
    end

    // Reset in the middle of a payload.
    bq = {8'hA5, 8'h05, 8'h01, 8'h02};
    foreach (bq[i]) send_byte(bq[i], 0);
    @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_outs", 32'({frm_data, frm_valid, frm_last, frm_len, busy}), 32'd0);
    check_eq("midrst_errs", 32'({frame_done, err_chk, err_len, err_ovf, err_tmo}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bq = {8'hA5, 8'h02, 8'h40, 8'h50, 8'h6E};
    pq = {8'h40, 8'h50};
    run_frame("after_rst", bq, 1, 0, 0, pq);

`ifdef UART_RX_TIMEOUT_EN
    begin
      int t0, e0, n;
      t0 = cnt_tmo;
      bq = {8'hA5, 8'h02, 8'h11};
      foreach (bq[i]) send_byte(bq[i], 0);
      e0 = last_byte_cyc;
      n = 0;
      while (cnt_tmo == t0 && n < 800) begin
        @(negedge clk);
        n++;
      end
      check_eq("tmo_pulse", cnt_tmo - t0, 32'd1);
      check_eq("tmo_cycle", tmo_cyc - e0, 32'd640);
      @(negedge clk);
      check_eq("tmo_idle", 32'(busy), 32'd0);
      got_q.delete(); got_last_q.delete(); got_len_q.delete();
      t0 = cnt_tmo;
      foreach (bq[i]) send_byte(bq[i], 0);
      e0 = last_byte_cyc;
      repeat (639) @(posedge clk);
      #1;
      rx_data  = 8'h22;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      check_eq("late_byte_cycle", cyc - e0, 32'd640);
      send_byte(8'hCB, 0);
      wait_idle("late");
      check_eq("late_no_tmo", cnt_tmo - t0, 32'd0);
      pq = {8'h11, 8'h22};
      check_payload("late", pq);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
